// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command parser: FSM state encoding,
// opcodes and the default frame header byte.
package uart_cmd_pkg;

    localparam logic [2:0] ST_HUNT = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_DHI  = 3'd2;
    localparam logic [2:0] ST_DLO  = 3'd3;
    localparam logic [2:0] ST_CSUM = 3'd4;

    localparam logic [7:0] OP_SET_X = 8'h01;
    localparam logic [7:0] OP_SET_Y = 8'h02;
    localparam logic [7:0] OP_PWR   = 8'h03;
    localparam logic [7:0] OP_RESET = 8'h04;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input and servo/power command outputs of the UART command parser.
// master = byte source and register consumer, slave = the parser itself.
interface uart_cmd_parser_if;

    logic [7:0]  rx_data;
    logic        rx_en;
    logic [15:0] servo_x;
    logic [15:0] servo_y;
    logic        power_en;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [7:0]  err_cnt;

    modport master (
        output rx_data, rx_en,
        input  servo_x, servo_y, power_en, cmd_valid, cmd_code, err_cnt
    );

    modport slave (
        input  rx_data, rx_en,
        output servo_x, servo_y, power_en, cmd_valid, cmd_code, err_cnt
    );

endinterface

// File: rtl/uart_cmd_timeout.sv
// Inter-byte gap counter: counts idle cycles while run_i is high, clears on
// clear_i, and flags expire_o on the cycle the count reaches TIMEOUT_CYCLES.
module uart_cmd_timeout #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd120000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic run_i,
    output logic expire_o
);

    logic [23:0] cnt_q, cnt_d;
    logic [24:0] cnt_inc;
    logic        limit_hit;

    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    always_comb begin
        cnt_inc   = {1'b0, cnt_q} + 25'd1;
        limit_hit = (cnt_inc >= {1'b0, TIMEOUT_CYCLES});
        cnt_d     = cnt_q;
        if (clear_i || !run_i) begin
            cnt_d = '0;
        end else if (limit_hit) begin
            cnt_d = TIMEOUT_CYCLES;
        end else begin
            cnt_d = cnt_inc[23:0];
        end
    end

    // A byte arriving on the limit cycle wins over the abort.
    assign expire_o = run_i && !clear_i && limit_hit;

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes 5-byte frames (HEADER, CMD, D_HI, D_LO, CSUM) into servo/power registers.
// Define UART_CMD_TIMEOUT_EN to compile in the inter-byte timeout abort path.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  HEADER         = DEFAULT_HEADER,
    parameter logic [15:0] SERVO_INIT     = 16'd1500,
    parameter logic [15:0] SERVO_MIN      = 16'd500,
    parameter logic [15:0] SERVO_MAX      = 16'd2500,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd120000
) (
    input logic              clk,
    input logic              reset,
    uart_cmd_parser_if.slave bus
);

    logic [2:0]  state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  dhi_q, dhi_d;
    logic [7:0]  dlo_q, dlo_d;
    logic [15:0] servo_x_q, servo_x_d;
    logic [15:0] servo_y_q, servo_y_d;
    logic        power_en_q, power_en_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [7:0]  cmd_code_q, cmd_code_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic [15:0] data_word;
    logic [15:0] data_clamped;
    logic [7:0]  csum_calc;
    logic        err_inc;
    logic        timeout_expire;

`ifdef UART_CMD_TIMEOUT_EN
    uart_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear_i (bus.rx_en),
        .run_i   (state_q != ST_HUNT),
        .expire_o(timeout_expire)
    );
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout_expire        = 1'b0;
`endif

    assign data_word = {dhi_q, dlo_q};
    assign csum_calc = cmd_q + dhi_q + dlo_q;

    always_comb begin
        if (data_word < SERVO_MIN) begin
            data_clamped = SERVO_MIN;
        end else if (data_word > SERVO_MAX) begin
            data_clamped = SERVO_MAX;
        end else begin
            data_clamped = data_word;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        dhi_d       = dhi_q;
        dlo_d       = dlo_q;
        servo_x_d   = servo_x_q;
        servo_y_d   = servo_y_q;
        power_en_d  = power_en_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = cmd_code_q;
        err_inc     = 1'b0;

        if (bus.rx_en) begin
            case (state_q)
                ST_HUNT: if (bus.rx_data == HEADER) state_d = ST_CMD;
                ST_CMD: begin
                    cmd_d   = bus.rx_data;
                    state_d = ST_DHI;
                end
                ST_DHI: begin
                    dhi_d   = bus.rx_data;
                    state_d = ST_DLO;
                end
                ST_DLO: begin
                    dlo_d   = bus.rx_data;
                    state_d = ST_CSUM;
                end
                ST_CSUM: begin
                    state_d = ST_HUNT;
                    if (bus.rx_data != csum_calc) begin
                        err_inc = 1'b1;
                    end else begin
                        cmd_valid_d = 1'b1;
                        cmd_code_d  = cmd_q;
                        case (cmd_q)
                            OP_SET_X: servo_x_d  = data_clamped;
                            OP_SET_Y: servo_y_d  = data_clamped;
                            OP_PWR:   power_en_d = dlo_q[0];
                            OP_RESET: begin
                                servo_x_d  = SERVO_INIT;
                                servo_y_d  = SERVO_INIT;
                                power_en_d = 1'b0;
                            end
                            default: begin
                                cmd_valid_d = 1'b0;
                                cmd_code_d  = cmd_code_q;
                                err_inc     = 1'b1;
                            end
                        endcase
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end else if (timeout_expire) begin
            state_d = ST_HUNT;
            err_inc = 1'b1;
        end

        err_cnt_d = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            cmd_q       <= '0;
            dhi_q       <= '0;
            dlo_q       <= '0;
            servo_x_q   <= SERVO_INIT;
            servo_y_q   <= SERVO_INIT;
            power_en_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            dhi_q       <= dhi_d;
            dlo_q       <= dlo_d;
            servo_x_q   <= servo_x_d;
            servo_y_q   <= servo_y_d;
            power_en_q  <= power_en_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.servo_x   = servo_x_q;
    assign bus.servo_y   = servo_y_q;
    assign bus.power_en  = power_en_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_code  = cmd_code_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser; timeout scenario depends
// on whether UART_CMD_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 100 here).
module tb_uart_cmd_parser;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   exp_err;

    uart_cmd_parser_if bus ();

    uart_cmd_parser #(
        .TIMEOUT_CYCLES(24'd100)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; the byte is sampled on the following posedge.
    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_en   = 1'b1;
        @(negedge clk);
        bus.rx_en   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        send_byte(b4);
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        bus.rx_en   = 1'b0;
        bus.rx_data = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.servo_x !== 16'd1500) begin errors++; $display("FAIL reset servo_x: got %0d want 1500", bus.servo_x); end
        checks++; if (bus.servo_y !== 16'd1500) begin errors++; $display("FAIL reset servo_y: got %0d want 1500", bus.servo_y); end
        checks++; if (bus.power_en !== 1'b0) begin errors++; $display("FAIL reset power_en: got %b want 0", bus.power_en); end
        checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL reset cmd_valid: got %b want 0", bus.cmd_valid); end
        checks++; if (bus.cmd_code !== 8'h00) begin errors++; $display("FAIL reset cmd_code: got %h want 00", bus.cmd_code); end
        checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL reset err_cnt: got %0d want 0", bus.err_cnt); end
        exp_err = 0;
    endtask

    task automatic test_set_x;
        send_frame(8'hA5, 8'h01, 8'h07, 8'hD0, 8'hD8);
        checks++; if (bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL set_x cmd_valid: got %b want 1", bus.cmd_valid); end
        checks++; if (bus.servo_x !== 16'd2000) begin errors++; $display("FAIL set_x servo_x: got %0d want 2000", bus.servo_x); end
        checks++; if (bus.cmd_code !== 8'h01) begin errors++; $display("FAIL set_x cmd_code: got %h want 01", bus.cmd_code); end
        checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL set_x err_cnt: got %0d want 0", bus.err_cnt); end
        @(negedge clk);
        checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL set_x pulse_width: got %b want 0", bus.cmd_valid); end
    endtask

    task automatic test_clamp;
        send_frame(8'hA5, 8'h02, 8'h00, 8'h64, 8'h66);
        checks++; if (bus.servo_y !== 16'd500) begin errors++; $display("FAIL clamp_low servo_y: got %0d want 500", bus.servo_y); end
        send_frame(8'hA5, 8'h02, 8'h0F, 8'hA0, 8'hB1);
        checks++; if (bus.servo_y !== 16'd2500) begin errors++; $display("FAIL clamp_high servo_y: got %0d want 2500", bus.servo_y); end
        send_frame(8'hA5, 8'h02, 8'h01, 8'hF4, 8'hF7);
        checks++; if (bus.servo_y !== 16'd500) begin errors++; $display("FAIL clamp_edge servo_y: got %0d want 500", bus.servo_y); end
        // Header bytes inside the frame are ordinary data: DATA = A5A5 clamps to 2500.
        send_frame(8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h4B);
        checks++; if (bus.servo_x !== 16'd2500) begin errors++; $display("FAIL hdr_as_data servo_x: got %0d want 2500", bus.servo_x); end
        checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL clamp err_cnt: got %0d want 0", bus.err_cnt); end
        send_frame(8'hA5, 8'h02, 8'h0F, 8'hA0, 8'hB1);
    endtask

    task automatic test_power_and_errors;
        send_frame(8'hA5, 8'h03, 8'h00, 8'h01, 8'h04);
        checks++; if (bus.power_en !== 1'b1) begin errors++; $display("FAIL power_on power_en: got %b want 1", bus.power_en); end
        checks++; if (bus.cmd_code !== 8'h03) begin errors++; $display("FAIL power_on cmd_code: got %h want 03", bus.cmd_code); end
        @(negedge clk);
        send_frame(8'hA5, 8'h03, 8'h00, 8'h00, 8'h05);
        exp_err++;
        checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL bad_csum cmd_valid: got %b want 0", bus.cmd_valid); end
        checks++; if (bus.power_en !== 1'b1) begin errors++; $display("FAIL bad_csum power_en: got %b want 1", bus.power_en); end
        checks++; if (bus.err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL bad_csum err_cnt: got %0d want %0d", bus.err_cnt, exp_err); end
        send_frame(8'hA5, 8'h09, 8'h00, 8'h00, 8'h09);
        exp_err++;
        checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("FAIL bad_op cmd_valid: got %b want 0", bus.cmd_valid); end
        checks++; if (bus.cmd_code !== 8'h03) begin errors++; $display("FAIL bad_op cmd_code: got %h want 03", bus.cmd_code); end
        checks++; if (bus.err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL bad_op err_cnt: got %0d want %0d", bus.err_cnt, exp_err); end
    endtask

    task automatic test_garbage_and_reset_op;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        send_frame(8'hA5, 8'h01, 8'h05, 8'hDC, 8'hE2);
        checks++; if (bus.servo_x !== 16'd1500) begin errors++; $display("FAIL garbage servo_x: got %0d want 1500", bus.servo_x); end
        checks++; if (bus.err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL garbage err_cnt: got %0d want %0d", bus.err_cnt, exp_err); end
        send_frame(8'hA5, 8'h01, 8'h07, 8'hD0, 8'hD8);
        send_frame(8'hA5, 8'h04, 8'h00, 8'h00, 8'h04);
        checks++; if (bus.servo_x !== 16'd1500) begin errors++; $display("FAIL op_reset servo_x: got %0d want 1500", bus.servo_x); end
        checks++; if (bus.servo_y !== 16'd1500) begin errors++; $display("FAIL op_reset servo_y: got %0d want 1500", bus.servo_y); end
        checks++; if (bus.power_en !== 1'b0) begin errors++; $display("FAIL op_reset power_en: got %b want 0", bus.power_en); end
        checks++; if (bus.cmd_code !== 8'h04) begin errors++; $display("FAIL op_reset cmd_code: got %h want 04", bus.cmd_code); end
        checks++; if (bus.cmd_valid !== 1'b1) begin errors++; $display("FAIL op_reset cmd_valid: got %b want 1", bus.cmd_valid); end
    endtask

`ifdef UART_CMD_TIMEOUT_EN
    task automatic test_timeout;
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (99) @(negedge clk);
        checks++; if (bus.err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL timeout_early err_cnt: got %0d want %0d", bus.err_cnt, exp_err); end
        @(negedge clk);
        exp_err++;
        checks++; if (bus.err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL timeout_abort err_cnt: got %0d want %0d", bus.err_cnt, exp_err); end
        send_frame(8'hA5, 8'h01, 8'h07, 8'hD0, 8'hD8);
        checks++; if (bus.servo_x !== 16'd2000) begin errors++; $display("FAIL timeout_resume servo_x: got %0d want 2000", bus.servo_x); end
        // Third byte lands exactly on the expiry cycle and must win.
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (99) @(negedge clk);
        send_byte(8'h05);
        send_byte(8'hDC);
        send_byte(8'hE2);
        checks++; if (bus.servo_x !== 16'd1500) begin errors++; $display("FAIL timeout_edge servo_x: got %0d want 1500", bus.servo_x); end
        checks++; if (bus.err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL timeout_edge err_cnt: got %0d want %0d", bus.err_cnt, exp_err); end
    endtask
`else
    task automatic test_timeout;
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (300) @(negedge clk);
        send_byte(8'h07);
        send_byte(8'hD0);
        send_byte(8'hD8);
        checks++; if (bus.servo_x !== 16'd2000) begin errors++; $display("FAIL no_timeout servo_x: got %0d want 2000", bus.servo_x); end
        checks++; if (bus.err_cnt !== 8'(exp_err)) begin errors++; $display("FAIL no_timeout err_cnt: got %0d want %0d", bus.err_cnt, exp_err); end
    endtask
`endif

    task automatic test_sync_reset;
        send_frame(8'hA5, 8'h03, 8'h00, 8'h01, 8'h04);
        send_frame(8'hA5, 8'h02, 8'h07, 8'hD0, 8'hD9);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h07);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        exp_err = 0;
        checks++; if (bus.servo_y !== 16'd1500) begin errors++; $display("FAIL sreset servo_y: got %0d want 1500", bus.servo_y); end
        checks++; if (bus.power_en !== 1'b0) begin errors++; $display("FAIL sreset power_en: got %b want 0", bus.power_en); end
        checks++; if (bus.cmd_code !== 8'h00) begin errors++; $display("FAIL sreset cmd_code: got %h want 00", bus.cmd_code); end
        checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL sreset err_cnt: got %0d want 0", bus.err_cnt); end
        // Tail of the discarded frame arrives in HUNT and must be ignored.
        send_byte(8'hD0);
        send_byte(8'hD8);
        send_frame(8'hA5, 8'h02, 8'h07, 8'hD0, 8'hD9);
        checks++; if (bus.servo_y !== 16'd2000) begin errors++; $display("FAIL sreset_after servo_y: got %0d want 2000", bus.servo_y); end
        checks++; if (bus.servo_x !== 16'd1500) begin errors++; $display("FAIL sreset_after servo_x: got %0d want 1500", bus.servo_x); end
        checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL sreset_after err_cnt: got %0d want 0", bus.err_cnt); end
    endtask

    task automatic test_err_saturation;
        for (int i = 0; i < 260; i++) begin
            send_frame(8'hA5, 8'h03, 8'h00, 8'h01, 8'h05);
        end
        checks++; if (bus.err_cnt !== 8'd255) begin errors++; $display("FAIL err_sat err_cnt: got %0d want 255", bus.err_cnt); end
        send_frame(8'hA5, 8'h01, 8'h07, 8'hD0, 8'hD8);
        checks++; if (bus.servo_x !== 16'd2000) begin errors++; $display("FAIL err_sat_after servo_x: got %0d want 2000", bus.servo_x); end
        checks++; if (bus.err_cnt !== 8'd255) begin errors++; $display("FAIL err_sat_after err_cnt: got %0d want 255", bus.err_cnt); end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_err = 0;
        reset   = 1'b1;
        bus.rx_en   = 1'b0;
        bus.rx_data = 8'h00;
        @(negedge clk);
        test_reset();
        test_set_x();
        test_clamp();
        test_power_and_errors();
        test_garbage_and_reset_op();
        test_timeout();
        test_sync_reset();
        test_err_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Receive-side command decoder for the pwm_servo_power UART link; it sits after the UART receiver. It consumes the byte stream (`rx_data`, qualified by a one-cycle `rx_en` strobe) and parses fixed 5-byte command frames. Validated commands update the servo pulse-width and power-enable registers, which drive the PWM/servo logic. It is the host-to-FPGA counterpart of the 23-byte telemetry frame generator on the transmit side.

## Interface
- `HEADER`, 8'hA5: frame start byte.
- `SERVO_INIT`, 16'd1500: reset value of both servo pulse registers, in µs.
- `SERVO_MIN`, 16'd500: lower clamp for servo values.
- `SERVO_MAX`, 16'd2500: upper clamp for servo values.
- `TIMEOUT_CYCLES`, 24'd120000: maximum idle gap between bytes inside a frame, in clk cycles.
- `clk`  in  1  system clock (same domain as the UART receiver).
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte; valid only when `rx_en`=1.
- `rx_en`  in  1  one-cycle strobe, one per received byte.
- `servo_x`  out  16  pan pulse width in µs.
- `servo_y`  out  16  tilt pulse width in µs.
- `power_en`  out  1  servo power rail enable.
- `cmd_valid`  out  1  one-cycle pulse after each accepted command.
- `cmd_code`  out  8  opcode of the last accepted command.
- `err_cnt`  out  8  count of rejected frames; saturates at 255.

## Operation
- Frame format: `HEADER`, CMD, D_HI, D_LO, CSUM.
  - CSUM = (CMD + D_HI + D_LO) mod 256.
  - DATA = {D_HI, D_LO}.
- States:
  - HUNT: on `rx_en`, if byte == `HEADER` go to CMD; otherwise stay.
  - CMD: latch CMD, go to DHI.
  - DHI: latch D_HI, go to DLO.
  - DLO: latch D_LO, go to CSUM.
  - CSUM: compare and execute or reject, then go to HUNT.
- A `HEADER` byte seen in CMD..CSUM is treated as plain data. There is no mid-frame resync; a bad frame is caught by its checksum.
- Opcodes:
  - 8'h01: `servo_x` ← clamp(DATA).
  - 8'h02: `servo_y` ← clamp(DATA).
  - 8'h03: `power_en` ← DATA[0].
  - 8'h04: `servo_x`, `servo_y`, `power_en` ← their reset values.
- clamp(v): `SERVO_MIN` if v < `SERVO_MIN`; `SERVO_MAX` if v > `SERVO_MAX`; otherwise v. Comparisons are 16-bit unsigned.
- Rejection: a checksum mismatch or an unknown opcode leaves the registers unchanged, does not pulse `cmd_valid`, and increments `err_cnt` (saturating).
- Reset values:
  - `servo_x` = `servo_y` = `SERVO_INIT`.
  - `power_en` = 0, `cmd_valid` = 0, `cmd_code` = 0, `err_cnt` = 0.
  - State = HUNT; timeout counter = 0.
- Reset asserted mid-frame discards the partial frame. No register update and no error count result from it.

## Timing
- Latency: registers, `cmd_code` and `cmd_valid` update on the clock edge after the cycle in which CSUM's `rx_en` is sampled. `cmd_valid` is high for exactly that one cycle.
- `rx_en` held high for consecutive cycles is treated as consecutive bytes. No back-pressure exists; every byte is consumed the cycle it is strobed.
- Timeout counter:
  - Runs only outside HUNT and clears on every `rx_en`.
  - When it reaches `TIMEOUT_CYCLES` with no `rx_en` that cycle, the state returns to HUNT and `err_cnt` increments.
  - If `rx_en` arrives in the same cycle the limit is reached, the byte wins: it is processed normally and the counter clears.
- The counter saturates and never wraps. `err_cnt` at 255 stays 255.

## Configuration
- `UART_CMD_TIMEOUT_EN`:
  - Defined: the inter-byte timeout counter and its abort path are compiled in.
  - Undefined: no counter exists, and a partial frame waits indefinitely for its remaining bytes. `TIMEOUT_CYCLES` is ignored, and timeouts never increment `err_cnt`.

## Structure
- Shared package `uart_cmd_pkg` holds:
  - the state encoding (HUNT, CMD, DHI, DLO, CSUM);
  - the opcode constants `OP_SET_X`, `OP_SET_Y`, `OP_PWR`, `OP_RESET`;
  - the default `HEADER` value.
- One sub-module is natural: `uart_cmd_timeout`, the gap counter with clear/run inputs and an expire output. It is instantiated only under `UART_CMD_TIMEOUT_EN`.
- The clamp is inline combinational logic in the top module.

## Test plan
- Frame A5 01 07 D0 D8 → `servo_x` = 2000, `cmd_valid` pulses once, `cmd_code` = 01, `err_cnt` = 0.
- Frame A5 02 00 64 66 (DATA = 100) → `servo_y` = 500 (clamped). Frame A5 02 0F A0 B1 (DATA = 4000) → `servo_y` = 2500.
- Frame A5 03 00 01 04 → `power_en` = 1. Then frame A5 03 00 01 05 (bad CSUM) → no change, no `cmd_valid`, `err_cnt` = 1. Then frame A5 09 00 00 09 (unknown opcode) → `err_cnt` = 2.
- Garbage 00 FF 12 then frame A5 01 05 DC E2 → HUNT skips the garbage, `servo_x` = 1500. Then A5 04 00 00 04 after changes → all registers return to reset values.
- With the macro defined and `TIMEOUT_CYCLES` = 100: send A5 01, idle 100 cycles → state returns to HUNT, `err_cnt` +1. Then a full valid frame is accepted. Repeat with `rx_en` landing exactly on the expiry cycle → no abort.
- Assert `reset` after A5 01 07 → outputs return to reset values. A following valid frame is accepted normally, and the total frame count never pushes `err_cnt` past 255.
